spi_bus_scheduler: RTL and testbench

- Shares one SPI master engine (shift/SCK generator) among NUM_REQ requesters using round-robin arbitration.
- Per transaction: latches the winner's byte and mode (CKP/CPH), asserts that requester's slave select, and waits a setup time.
- Then pulses the engine start, waits for engine completion or a watchdog timeout, and returns the received byte.
- Sits between the CPU-side request logic and the SPI master engine; it drives SS toward the receiver_SPI slaves.

---
 rtl/spi_bus_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_spi_bus_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_scheduler.sv
// Round-robin scheduler that shares one SPI master engine among NUM_REQ requesters,
// sequencing slave select, setup delay, engine start, watchdog and inter-transaction gap.
//
// state  | meaning
// IDLE   | arbitrate pending requests from the round-robin pointer
// SETUP  | SS low, tx byte and mode latched, waiting SETUP_CYCLES
// START  | one-cycle engine start pulse, watchdog cleared
// WAIT   | waiting for eng_done or watchdog expiry
// FINISH | ack (and timeout_err if aborted) to the granted requester
// GAP    | SS high for GAP_CYCLES before returning to IDLE
module spi_bus_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [2*NUM_REQ-1:0]   req_mode,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             rx_data,
    output logic                   timeout_err,
    output logic                   eng_start,
    output logic [7:0]             eng_data,
    output logic                   CKP,
    output logic                   CPH,
    output logic [NUM_REQ-1:0]     SS,
    input  logic                   eng_done,
    input  logic [7:0]             eng_rx_data
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WD_W-1:0]     wdog_q, wdog_d, wdog_inc;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ss_q, ss_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic [7:0]          data_q, data_d;
    logic                ckp_q, ckp_d;
    logic                cph_q, cph_d;
    logic [7:0]          rx_q, rx_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [7:0]          win_data;
    logic [1:0]          win_mode;

    // First pending request at or above the pointer, wrapping back to 0.
    always_comb begin : arb
        int cand;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
        win_onehot[win_idx] = 1'b1;
        win_data = req_data[8*int'(win_idx) +: 8];
        win_mode = req_mode[2*int'(win_idx) +: 2];
    end

    assign wdog_inc = wdog_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdog_d  = wdog_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ss_d    = ss_q;
        ack_d   = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        data_d  = data_q;
        ckp_d   = ckp_q;
        cph_d   = cph_q;
        rx_d    = rx_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_SETUP;
                    idx_d   = win_idx;
                    gnt_d   = win_onehot;
                    ss_d    = ~win_onehot;
                    data_d  = win_data;
                    ckp_d   = win_mode[1];
                    cph_d   = win_mode[0];
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                    wdog_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                wdog_d  = '0;
            end
            ST_WAIT: begin
                // A done arriving on the expiry cycle still counts as a completed transfer.
                if (eng_done) begin
                    state_d = ST_FINISH;
                    rx_d    = eng_rx_data;
                    ack_d   = gnt_q;
                end else if (wdog_inc == WD_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_FINISH;
                    rx_d    = 8'h00;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            ST_FINISH: begin
                state_d = ST_GAP;
                gnt_d   = '0;
                ss_d    = '1;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wdog_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ss_q    <= '1;
            ack_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            ckp_q   <= 1'b0;
            cph_q   <= 1'b0;
            rx_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ss_q    <= ss_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            start_q <= start_d;
            data_q  <= data_d;
            ckp_q   <= ckp_d;
            cph_q   <= cph_d;
            rx_q    <= rx_d;
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign rx_data     = rx_q;
    assign timeout_err = err_q;
    assign eng_start   = start_q;
    assign eng_data    = data_q;
    assign CKP         = ckp_q;
    assign CPH         = cph_q;
    assign SS          = ss_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Scoreboard bench for spi_bus_scheduler: an engine model answers eng_start,
// expected transactions are queued at stimulus time and popped on each ack.
module tb_spi_bus_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic [7:0]  req_mode = 8'h0;
    logic [3:0]  gnt, ack, SS;
    logic [7:0]  rx_data, eng_data;
    logic        timeout_err, eng_start, CKP, CPH;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rx_data = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_bus_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
        .gnt(gnt), .ack(ack), .rx_data(rx_data), .timeout_err(timeout_err),
        .eng_start(eng_start), .eng_data(eng_data), .CKP(CKP), .CPH(CPH), .SS(SS),
        .eng_done(eng_done), .eng_rx_data(eng_rx_data)
    );

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] rx;
        logic       err;
        logic [7:0] data;
        logic [1:0] mode;
    } txn_t;

    txn_t exp_q[$];

    // Engine model: eng_lat cycles after the start cycle, pulse done; 0 = never answer.
    int         eng_lat = 0;
    logic [7:0] eng_rx_val = 8'h00;
    int         late_cnt = 0;

    initial begin
        int cnt;
        int late_seen;
        cnt = -1;
        late_seen = 0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done    = 1'b1;
                    eng_rx_data = eng_rx_val;
                    cnt         = -1;
                end
            end
            if (late_cnt != late_seen) begin
                late_seen   = late_cnt;
                eng_done    = 1'b1;
                eng_rx_data = 8'hEE;
            end
            if (eng_start && eng_lat > 0) cnt = eng_lat;
            if (rst) cnt = -1;
        end
    end

    // Bus monitor sampled on the falling edge.
    int ss_multi = 0, gap_viol = 0, last_gap = 0, mode_viol = 0;

    initial begin
        logic [1:0] prev_mode;
        logic [3:0] prev_ss;
        int high_run;
        bit seen_low;
        prev_mode = 2'b00; prev_ss = 4'hF; high_run = 0; seen_low = 0;
        forever begin
            @(negedge clk);
            if ($countones(~SS) > 1) ss_multi++;
            if (!rst && ({CKP, CPH} != prev_mode) && (prev_ss != 4'hF)) mode_viol++;
            if (rst) begin
                seen_low = 0;
                high_run = 0;
            end else if (SS == 4'hF) begin
                high_run++;
            end else begin
                if (prev_ss == 4'hF && seen_low) begin
                    last_gap = high_run;
                    if (high_run < 4) gap_viol++;
                end
                seen_low = 1;
                high_run = 0;
            end
            prev_mode = {CKP, CPH};
            prev_ss   = SS;
        end
    end

    function automatic txn_t mk(input logic [3:0] a, input logic [7:0] r, input logic er,
                                input logic [7:0] d, input logic [1:0] m);
        txn_t t;
        t.ack = a; t.rx = r; t.err = er; t.data = d; t.mode = m;
        return t;
    endfunction

    // Observe until an ack: SS-low cycles, start pulses, and cycles between start and ack.
    task automatic wait_ack(input int budget, output logic got, output txn_t obs,
                            output int ss_low, output int starts, output int wait_cyc);
        bit started;
        started = 0;
        got = 1'b0; obs = '0; ss_low = 0; starts = 0; wait_cyc = 0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk); #1;
            if (SS != 4'hF) ss_low++;
            if (ack != 4'h0) begin
                got      = 1'b1;
                obs.ack  = ack;
                obs.rx   = rx_data;
                obs.err  = timeout_err;
                obs.data = eng_data;
                obs.mode = {CKP, CPH};
            end else if (started) begin
                wait_cyc++;
            end
            if (eng_start) begin
                starts++;
                started = 1;
            end
        end
    endtask

    task automatic wait_start(input int budget, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            seen = eng_start;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (SS !== 4'hF) begin n_fail++; $display("FAIL reset_ss: got %b expected 1111", SS); end
        n_tests++; if (gnt !== 4'h0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_tests++; if (ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
        n_tests++; if ({timeout_err, eng_start} !== 2'b00) begin n_fail++; $display("FAIL reset_err_start: got %b expected 00", {timeout_err, eng_start}); end
        n_tests++; if (eng_data !== 8'h00) begin n_fail++; $display("FAIL reset_eng_data: got %h expected 00", eng_data); end
        n_tests++; if ({CKP, CPH} !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b expected 00", {CKP, CPH}); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++; if (SS !== 4'hF || gnt !== 4'h0) begin n_fail++; $display("FAIL idle_no_req: got ss=%b gnt=%b expected 1111/0000", SS, gnt); end
    endtask

    task automatic test_single();
        logic got; txn_t obs, e; int ss_low, starts, wc;
        eng_lat = 10; eng_rx_val = 8'h3C;
        req_data[7:0] = 8'hA5; req_mode[1:0] = 2'b00; req = 4'b0001;
        exp_q.push_back(mk(4'b0001, 8'h3C, 1'b0, 8'hA5, 2'b00));
        wait_ack(100, got, obs, ss_low, starts, wc);
        req = 4'h0;
        e = exp_q.pop_front();
        n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL single_txn: got %h (seen=%b) expected %h", obs, got, e); end
        n_tests++; if (ss_low !== 14) begin n_fail++; $display("FAIL single_ss_low: got %0d cycles expected 14", ss_low); end
        n_tests++; if (starts !== 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", starts); end
        n_tests++; if (wc !== 10) begin n_fail++; $display("FAIL single_wait: got %0d expected 10", wc); end
        @(posedge clk); #1;
        n_tests++; if (SS !== 4'hF || gnt !== 4'h0 || ack !== 4'h0) begin n_fail++; $display("FAIL single_release: got ss=%b gnt=%b ack=%b expected 1111/0000/0000", SS, gnt, ack); end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_round_robin();
        logic got; txn_t obs, e; int ss_low, starts, wc, base_multi, base_gap, idx;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        base_multi = ss_multi; base_gap = gap_viol;
        eng_lat = 3;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_mode = {2'd3, 2'd2, 2'd1, 2'd0};
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            idx = k % 4;
            eng_rx_val = 8'hC0 + 8'(k);
            exp_q.push_back(mk(4'(1 << idx), 8'hC0 + 8'(k), 1'b0, 8'h10 + 8'(idx), 2'(idx)));
            wait_ack(100, got, obs, ss_low, starts, wc);
            e = exp_q.pop_front();
            n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL rr_txn%0d: got %h (seen=%b) expected %h", k, obs, got, e); end
        end
        req = 4'h0;
        repeat (8) @(posedge clk);
        #1;
        n_tests++; if (ss_multi - base_multi !== 0) begin n_fail++; $display("FAIL rr_ss_overlap: got %0d cycles expected 0", ss_multi - base_multi); end
        n_tests++; if (gap_viol - base_gap !== 0) begin n_fail++; $display("FAIL rr_gap_short: got %0d gaps expected 0", gap_viol - base_gap); end
        n_tests++; if (last_gap !== 4) begin n_fail++; $display("FAIL rr_gap_len: got %0d expected 4", last_gap); end
    endtask

    task automatic test_mode_latch();
        logic got, seen; txn_t obs, e; int ss_low, starts, wc, base_mode;
        base_mode = mode_viol;
        eng_lat = 8; eng_rx_val = 8'h44;
        req_data[23:16] = 8'h33; req_mode[5:4] = 2'b11; req = 4'b0100;
        exp_q.push_back(mk(4'b0100, 8'h44, 1'b0, 8'h33, 2'b11));
        wait_start(50, seen);
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mode_start: got %b expected 1", seen); end
        req_mode[5:4] = 2'b00; req_data[23:16] = 8'h99;
        wait_ack(100, got, obs, ss_low, starts, wc);
        e = exp_q.pop_front();
        n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL mode_first: got %h (seen=%b) expected %h", obs, got, e); end
        exp_q.push_back(mk(4'b0100, 8'h44, 1'b0, 8'h99, 2'b00));
        wait_ack(100, got, obs, ss_low, starts, wc);
        req = 4'h0;
        e = exp_q.pop_front();
        n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL mode_second: got %h (seen=%b) expected %h", obs, got, e); end
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (mode_viol - base_mode !== 0) begin n_fail++; $display("FAIL mode_change_ss_low: got %0d expected 0", mode_viol - base_mode); end
    endtask

    task automatic test_timeout();
        logic got; txn_t obs, e; int ss_low, starts, wc, spurious;
        eng_lat = 0;
        req_data[31:24] = 8'hD3; req_mode[7:6] = 2'b01; req = 4'b1000;
        exp_q.push_back(mk(4'b1000, 8'h00, 1'b1, 8'hD3, 2'b01));
        wait_ack(200, got, obs, ss_low, starts, wc);
        req = 4'h0;
        e = exp_q.pop_front();
        n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL timeout_txn: got %h (seen=%b) expected %h", obs, got, e); end
        n_tests++; if (wc !== 64) begin n_fail++; $display("FAIL timeout_wait: got %0d expected 64", wc); end
        late_cnt++;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ack != 4'h0 || timeout_err || SS != 4'hF) spurious++;
        end
        n_tests++; if (spurious !== 0) begin n_fail++; $display("FAIL late_done_ignored: got %0d bad cycles expected 0", spurious); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL late_done_rx: got %h expected 00", rx_data); end
    endtask

    task automatic test_expiry_race();
        logic got; txn_t obs, e; int ss_low, starts, wc;
        eng_lat = 64; eng_rx_val = 8'h77;
        req_data[7:0] = 8'h5E; req_mode[1:0] = 2'b10; req = 4'b0001;
        exp_q.push_back(mk(4'b0001, 8'h77, 1'b0, 8'h5E, 2'b10));
        wait_ack(200, got, obs, ss_low, starts, wc);
        req = 4'h0;
        e = exp_q.pop_front();
        n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL race_txn: got %h (seen=%b) expected %h", obs, got, e); end
        n_tests++; if (wc !== 64) begin n_fail++; $display("FAIL race_wait: got %0d expected 64", wc); end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic got, seen; txn_t obs, e; int ss_low, starts, wc;
        eng_lat = 0;
        req = 4'b0010;
        wait_start(50, seen);
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_start: got %b expected 1", seen); end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (SS !== 4'hF || gnt !== 4'h0 || ack !== 4'h0) begin n_fail++; $display("FAIL rstmid_release: got ss=%b gnt=%b ack=%b expected 1111/0000/0000", SS, gnt, ack); end
        rst = 1'b0;
        eng_lat = 2; eng_rx_val = 8'hA0;
        req_data[15:0] = 16'h0201; req_mode[3:0] = 4'b0000;
        req = 4'b0011;
        exp_q.push_back(mk(4'b0001, 8'hA0, 1'b0, 8'h01, 2'b00));
        wait_ack(100, got, obs, ss_low, starts, wc);
        req = 4'b0010;
        e = exp_q.pop_front();
        n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL rstmid_first: got %h (seen=%b) expected %h", obs, got, e); end
        eng_rx_val = 8'hA1;
        exp_q.push_back(mk(4'b0010, 8'hA1, 1'b0, 8'h02, 2'b00));
        wait_ack(100, got, obs, ss_low, starts, wc);
        req = 4'h0;
        e = exp_q.pop_front();
        n_tests++; if (!got || obs !== e) begin n_fail++; $display("FAIL rstmid_second: got %h (seen=%b) expected %h", obs, got, e); end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mode_latch();
        test_timeout();
        test_expiry_race();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
